ex_stage: RTL
=============

Name: ex_stage

Overview:
Execute stage of the RV32I 5-stage pipeline. It consumes the ID/EX pipeline registers produced by the decode stage and forwards operands from MEM and WB. It performs the ALU operation, resolves branches and jumps, and drives the redirect that flushes IF/ID. It also loads the EX/MEM pipeline registers and contains a RUN/HALT state machine that halts the pipeline on an exception.

Parameters:
REG_DATA_WIDTH, 32, datapath width
REGFILE_ADDR_WIDTH, 5, register address width
ALU_OP_WIDTH, 4, ALU opcode width

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
ID_PC, ID_PC_dest, ID_Immediate_1, ID_Immediate_2  in  32 each  PC, precomputed branch/jump target, immediates
ID_Rs1_data, ID_Rs2_data  in  32 each  regfile read data
ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr  in  5 each  register addresses
ID_ALU_source_sel  in  2  operand select
ID_ALU_op  in  4  ALU opcode
ID_Mem_op  in  3  funct3 (load/store width, or branch condition)
ID_Branch_flag, ID_Jump, ID_Mem_wr_en, ID_Mem_rd_en, ID_RegFile_wr_en, ID_MemToReg, ID_Exception  in  1 each  decoded controls
EX_Stall  in  1  hold EX/MEM registers
WB_Rd_addr  in  5  writeback address
WB_Rd_data  in  32  writeback data
WB_RegFile_wr_en  in  1  writeback enable
EX_Redirect  out  1  combinational: taken branch/jump, flush IF/ID
EX_Redirect_PC  out  32  combinational: redirect target
EX_ALU_result, EX_Rs2_data  out  32 each  registered result and forwarded store data
EX_Rd_addr  out  5  registered
EX_Mem_op  out  3  registered
EX_Mem_wr_en, EX_Mem_rd_en, EX_RegFile_wr_en, EX_MemToReg, EX_Exception  out  1 each  registered
EX_Halted  out  1  registered, state == HALT

Behaviour:
- Reset (synchronous, active-high) values: all registered outputs are 0 and the state is RUN. Reset has priority over EX_Stall and over every other condition.
- Operand forwarding, per source (rs1 and rs2):
  - If addr == 0, use 0.
  - Else if EX_RegFile_wr_en && !EX_MemToReg && EX_Rd_addr == addr, use EX_ALU_result (MEM stage has priority).
  - Else if WB_RegFile_wr_en && WB_Rd_addr == addr, use WB_Rd_data.
  - Else use ID_RsX_data.
  - A load in MEM is never forwarded; the external hazard unit stalls for load-use.
- Operand select by ID_ALU_source_sel:
  - 0: A = fwd_rs1, B = fwd_rs2.
  - 1: A = fwd_rs1, B = Imm2.
  - 2: A = Imm1, B = Imm2 (AUIPC/LUI).
  - 3: A = ID_PC, B = 4 (JAL/JALR link).
- ALU opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
  - 11-15 produce 0.
  - Shifts use B[4:0]. All arithmetic is modulo 2^32.
- Branch condition when ID_Branch_flag is set, compared on fwd_rs1 vs fwd_rs2 and selected by ID_Mem_op:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010 and 011 mean not taken.
- take = ID_Jump | (ID_Branch_flag & cond).
- EX_Redirect = take & !misalign & state == RUN & !EX_Stall. EX_Redirect_PC = ID_PC_dest.
- misalign = take & ID_PC_dest[1:0] != 0. It sets the registered EX_Exception and suppresses the redirect.
- Registered EX/MEM update on each edge:
  - If EX_Stall, hold all EX_* registers.
  - Else if state == HALT, load a bubble: all controls 0, data registers hold.
  - Else load ALU result, fwd_rs2, and the ID controls.
  - EX_Exception = ID_Exception | misalign. When EX_Exception is loaded as 1, EX_RegFile_wr_en, EX_Mem_wr_en and EX_Mem_rd_en load 0.
- State machine:
  - RUN to HALT on the edge where EX_Exception is loaded as 1.
  - HALT is sticky; only Reset returns to RUN.
  - In HALT, EX_Redirect = 0 and EX_Exception holds 1.
- Stall and redirect in the same cycle: the stall wins; no redirect, since the instruction re-presents next cycle.
- Latency: result is in EX_* 1 cycle after ID_* is presented; redirect is in the same cycle.

Test Plan:
1. ADD x3,x1,x2 (sel 0, op 0, rs1 data 5, rs2 data 7) -> next cycle EX_ALU_result = 12, EX_Rd_addr = 3, EX_RegFile_wr_en = 1.
2. Back-to-back dependency: EX holds Rd = 3, result 12, wr_en 1; WB writes x3 = 99; ID rs1 = 3 with stale data 0 -> MEM operand is used, A = 12. Repeat with EX_Rd_addr = 0 -> A = 0 when rs1 = x0.
3. BLT with rs1 = 0xFFFFFFFF, rs2 = 1, PC_dest = 0x100 -> EX_Redirect = 1 and EX_Redirect_PC = 0x100 in the same cycle. BLTU with the same operands -> EX_Redirect = 0.
4. JAL with PC = 0x40 and sel 3 -> EX_ALU_result = 0x44, EX_Redirect = 1. With PC_dest = 0x102 -> EX_Redirect = 0, EX_Exception = 1, EX_RegFile_wr_en = 0, and EX_Halted = 1 next cycle.
5. EX_Stall held 3 cycles with a taken branch presented -> EX_* unchanged for 3 cycles and EX_Redirect = 0; stall released -> redirect fires and registers update.
6. In HALT, present valid ADDs -> all EX control outputs remain 0. Assert Reset for 1 cycle -> EX_Halted = 0 and all outputs = 0; the next ADD executes normally.

Source files
------------

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs, WB forwarding inputs and EX/MEM outputs of the execute stage
interface ex_stage_if #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH = 4
);
    logic [REG_DATA_WIDTH-1:0] ID_PC, ID_PC_dest, ID_Immediate_1, ID_Immediate_2, ID_Rs1_data, ID_Rs2_data;
    logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr;
    logic [1:0] ID_ALU_source_sel;
    logic [ALU_OP_WIDTH-1:0] ID_ALU_op;
    logic [2:0] ID_Mem_op;
    logic ID_Branch_flag, ID_Jump, ID_Mem_wr_en, ID_Mem_rd_en, ID_RegFile_wr_en, ID_MemToReg, ID_Exception;
    logic EX_Stall;
    logic [REGFILE_ADDR_WIDTH-1:0] WB_Rd_addr;
    logic [REG_DATA_WIDTH-1:0] WB_Rd_data;
    logic WB_RegFile_wr_en;
    logic EX_Redirect;
    logic [REG_DATA_WIDTH-1:0] EX_Redirect_PC, EX_ALU_result, EX_Rs2_data;
    logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr;
    logic [2:0] EX_Mem_op;
    logic EX_Mem_wr_en, EX_Mem_rd_en, EX_RegFile_wr_en, EX_MemToReg, EX_Exception, EX_Halted;
    modport master (
        output ID_PC, ID_PC_dest, ID_Immediate_1, ID_Immediate_2, ID_Rs1_data, ID_Rs2_data,
               ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr, ID_ALU_source_sel, ID_ALU_op, ID_Mem_op,
               ID_Branch_flag, ID_Jump, ID_Mem_wr_en, ID_Mem_rd_en, ID_RegFile_wr_en, ID_MemToReg,
               ID_Exception, EX_Stall, WB_Rd_addr, WB_Rd_data, WB_RegFile_wr_en,
        input  EX_Redirect, EX_Redirect_PC, EX_ALU_result, EX_Rs2_data, EX_Rd_addr, EX_Mem_op,
               EX_Mem_wr_en, EX_Mem_rd_en, EX_RegFile_wr_en, EX_MemToReg, EX_Exception, EX_Halted
    );
    modport slave (
        input  ID_PC, ID_PC_dest, ID_Immediate_1, ID_Immediate_2, ID_Rs1_data, ID_Rs2_data,
               ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr, ID_ALU_source_sel, ID_ALU_op, ID_Mem_op,
               ID_Branch_flag, ID_Jump, ID_Mem_wr_en, ID_Mem_rd_en, ID_RegFile_wr_en, ID_MemToReg,
               ID_Exception, EX_Stall, WB_Rd_addr, WB_Rd_data, WB_RegFile_wr_en,
        output EX_Redirect, EX_Redirect_PC, EX_ALU_result, EX_Rs2_data, EX_Rd_addr, EX_Mem_op,
               EX_Mem_wr_en, EX_Mem_rd_en, EX_RegFile_wr_en, EX_MemToReg, EX_Exception, EX_Halted
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage with forwarding, ALU, branch resolution, EX/MEM registers and RUN/HALT FSM
module ex_stage #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH = 4
) (
    input logic Clk,
    input logic Reset,
    ex_stage_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nxt;
    logic [REG_DATA_WIDTH-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu;
    logic [4:0] shamt;
    logic cond, take, misalign, exc_nxt, run;
    always_comb begin
        fwd_rs1 = bus.ID_Rs1_addr == '0 ? '0 :
                  (bus.EX_RegFile_wr_en && !bus.EX_MemToReg && bus.EX_Rd_addr == bus.ID_Rs1_addr) ? bus.EX_ALU_result :
                  (bus.WB_RegFile_wr_en && bus.WB_Rd_addr == bus.ID_Rs1_addr) ? bus.WB_Rd_data : bus.ID_Rs1_data;
        fwd_rs2 = bus.ID_Rs2_addr == '0 ? '0 :
                  (bus.EX_RegFile_wr_en && !bus.EX_MemToReg && bus.EX_Rd_addr == bus.ID_Rs2_addr) ? bus.EX_ALU_result :
                  (bus.WB_RegFile_wr_en && bus.WB_Rd_addr == bus.ID_Rs2_addr) ? bus.WB_Rd_data : bus.ID_Rs2_data;
        op_a = bus.ID_ALU_source_sel == 2'd2 ? bus.ID_Immediate_1 :
               bus.ID_ALU_source_sel == 2'd3 ? bus.ID_PC : fwd_rs1;
        op_b = bus.ID_ALU_source_sel == 2'd0 ? fwd_rs2 :
               bus.ID_ALU_source_sel == 2'd3 ? REG_DATA_WIDTH'(4) : bus.ID_Immediate_2;
        shamt = op_b[4:0];
    end
    always_comb begin
        alu = '0;
        case (bus.ID_ALU_op)
            4'd0: alu = op_a + op_b;
            4'd1: alu = op_a - op_b;
            4'd2: alu = op_a << shamt;
            4'd3: alu = REG_DATA_WIDTH'($signed(op_a) < $signed(op_b));
            4'd4: alu = REG_DATA_WIDTH'(op_a < op_b);
            4'd5: alu = op_a ^ op_b;
            4'd6: alu = op_a >> shamt;
            4'd7: alu = $signed(op_a) >>> shamt;
            4'd8: alu = op_a | op_b;
            4'd9: alu = op_a & op_b;
            4'd10: alu = op_b;
            default: alu = '0;
        endcase
    end
    always_comb begin
        cond = 1'b0;
        case (bus.ID_Mem_op)
            3'b000: cond = fwd_rs1 == fwd_rs2;
            3'b001: cond = fwd_rs1 != fwd_rs2;
            3'b100: cond = $signed(fwd_rs1) < $signed(fwd_rs2);
            3'b101: cond = $signed(fwd_rs1) >= $signed(fwd_rs2);
            3'b110: cond = fwd_rs1 < fwd_rs2;
            3'b111: cond = fwd_rs1 >= fwd_rs2;
            default: cond = 1'b0;
        endcase
    end
    always_comb begin
        run = state == RUN;
        take = bus.ID_Jump | (bus.ID_Branch_flag & cond);
        misalign = take & (bus.ID_PC_dest[1:0] != 2'b00);
        exc_nxt = bus.ID_Exception | misalign;
        bus.EX_Redirect = take & !misalign & run & !bus.EX_Stall;
        bus.EX_Redirect_PC = bus.ID_PC_dest;
        bus.EX_Halted = state == HALT;
        state_nxt = (run && !bus.EX_Stall && exc_nxt) ? HALT : state;
    end
    always_ff @(posedge Clk) state <= Reset ? RUN : state_nxt;
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bus.EX_ALU_result <= '0;
            bus.EX_Rs2_data <= '0;
            bus.EX_Rd_addr <= '0;
            bus.EX_Mem_op <= '0;
            bus.EX_Mem_wr_en <= 1'b0;
            bus.EX_Mem_rd_en <= 1'b0;
            bus.EX_RegFile_wr_en <= 1'b0;
            bus.EX_MemToReg <= 1'b0;
            bus.EX_Exception <= 1'b0;
        end else if (!bus.EX_Stall) begin
            bus.EX_ALU_result <= run ? alu : bus.EX_ALU_result;
            bus.EX_Rs2_data <= run ? fwd_rs2 : bus.EX_Rs2_data;
            bus.EX_Rd_addr <= run ? bus.ID_Rd_addr : bus.EX_Rd_addr;
            bus.EX_Mem_op <= run ? bus.ID_Mem_op : '0;
            bus.EX_Mem_wr_en <= run & bus.ID_Mem_wr_en & !exc_nxt;
            bus.EX_Mem_rd_en <= run & bus.ID_Mem_rd_en & !exc_nxt;
            bus.EX_RegFile_wr_en <= run & bus.ID_RegFile_wr_en & !exc_nxt;
            bus.EX_MemToReg <= run & bus.ID_MemToReg;
            bus.EX_Exception <= run ? exc_nxt : bus.EX_Exception;
        end
    end
endmodule
